ctrl_pipe_hazard: RTL
=====================

// Module: ctrl_pipe_hazard
// PURPOSE
//   Consumer side of the main decoder's control bundle. Carries the decoded controls from ID
//   through the ID/EX, EX/MEM and MEM/WB stages. Detects load-use hazards and inserts bubbles.
//   Squashes wrong-path instructions when a branch resolves taken in MEM.
//   Drives PC/IF-ID write enables and keeps a saturating stall counter.
// PARAMETERS
//   RA_W    5   register-address width (rs1/rs2/rd)
//   CNT_W   16  width of stall_cnt
// PORTS
//   clk             in   1      rising-edge clock, single domain
//   reset           in   1      synchronous, active-high
//   id_valid        in   1      ID holds a decoded, legal instruction
//   id_branch       in   1      decoder Branch
//   id_memread      in   1      decoder MemRead
//   id_memtoreg     in   1      decoder MemtoReg (may be X when id_regwrite=0)
//   id_aluop        in   2      decoder ALUOp
//   id_memwrite     in   1      decoder MemWrite
//   id_alusrc       in   1      decoder ALUSrc
//   id_regwrite     in   1      decoder RegWrite
//   id_rs1,id_rs2   in   RA_W   source register fields in ID
//   id_rd           in   RA_W   destination field in ID
//   mem_zero        in   1      ALU zero flag registered into MEM
//   ex_branch,ex_memread,ex_memtoreg,ex_memwrite,ex_alusrc,ex_regwrite  out 1  ID/EX controls
//   ex_aluop        out  2      ID/EX ALUOp
//   ex_rd           out  RA_W   ID/EX destination
//   mem_branch,mem_memread,mem_memwrite,mem_memtoreg,mem_regwrite  out 1  EX/MEM controls
//   mem_rd          out  RA_W   EX/MEM destination
//   wb_memtoreg,wb_regwrite  out 1  MEM/WB controls
//   wb_rd           out  RA_W   MEM/WB destination
//   pc_write        out  1      PC load enable
//   ifid_write      out  1      IF/ID load enable
//   ifid_flush      out  1      clear IF/ID to NOP
//   br_taken        out  1      = mem_branch & mem_zero; PC mux selects branch target
//   stall_cnt       out  CNT_W  count of load-use stall cycles, saturating
// BEHAVIOUR
//   - Reset: all stage registers, their outputs and stall_cnt go to 0.
//     While reset=1: pc_write=0, ifid_write=0, ifid_flush=1.
//   - Bubble: all control bits 0, rd=0. Takes effect at the edge.
//   - Scrubbing at ID/EX capture:
//     - memtoreg := id_memtoreg & id_regwrite (never propagate X).
//     - rd := id_regwrite ? id_rd : 0.
//     - id_valid=0 -> bubble.
//   - Hazard detection (combinational):
//     - hz = ex_memread & (ex_rd!=0) & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
//     - br_taken = mem_branch & mem_zero.
//   - Priority per cycle: reset > br_taken > hz > normal.
//     - br_taken: ID/EX<=bubble, EX/MEM<=bubble, MEM/WB<=normal advance.
//       Outputs pc_write=1, ifid_write=1, ifid_flush=1.
//     - hz, no br_taken: ID/EX<=bubble; EX/MEM and MEM/WB advance.
//       Outputs pc_write=0, ifid_write=0, ifid_flush=0.
//       stall_cnt += 1, saturating at all-ones.
//     - normal: all stages advance, pc_write=1, ifid_write=1, ifid_flush=0.
//   - A hz coincident with br_taken is discarded and not counted; the stalled instruction is
//     wrong-path.
//   - Latency: ID->EX, EX->MEM and MEM->WB are 1 cycle each. WB controls appear 3 edges after ID.
//   - Hazard stalls last exactly 1 cycle. After the bubble ex_memread=0, so hz deasserts.
//   - Forwarded-path hazards are not handled here. x0 as destination never stalls.
// TESTING
//   1. Reset held 2 cycles mid-stream:
//      - all stage outputs 0, stall_cnt=0, pc_write=0, ifid_flush=1.
//      - first R-type after release: wb_regwrite=1 exactly 3 edges after ID.
//   2. lw x5 then add x6,x5,x7:
//      - one cycle with pc_write=0, ifid_write=0, ex_* bubble; stall_cnt=1.
//      - add reaches EX the next cycle.
//   3. lw x0 then add x6,x0,x1:
//      - no stall; pc_write stays 1; stall_cnt stays 0.
//   4. beq with mem_zero=1 at MEM while a dependent lw/use pair sits in EX/ID:
//      - br_taken=1, ifid_flush=1, ID/EX and EX/MEM bubbled, stall_cnt unchanged.
//   5. sw followed by beq with id_memtoreg=X:
//      - ex_memtoreg=0, ex_rd=0, ex_memwrite=1 then ex_branch=1; no X on any output.
//   6. Force CNT_W=2, four back-to-back load-use pairs:
//      - stall_cnt reads 1,2,3,3.

Source files
------------

// File: rtl/ctrl_pipe_hazard.sv
// Control-bundle pipeline ID/EX -> EX/MEM -> MEM/WB with load-use stall,
// taken-branch squash, fetch enables and a saturating stall counter.
module ctrl_pipe_hazard #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_branch,
  input  logic             id_memread,
  input  logic             id_memtoreg,
  input  logic [1:0]       id_aluop,
  input  logic             id_memwrite,
  input  logic             id_alusrc,
  input  logic             id_regwrite,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             mem_zero,
  output logic             ex_branch,
  output logic             ex_memread,
  output logic             ex_memtoreg,
  output logic             ex_memwrite,
  output logic             ex_alusrc,
  output logic             ex_regwrite,
  output logic [1:0]       ex_aluop,
  output logic [RA_W-1:0]  ex_rd,
  output logic             mem_branch,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic             mem_memtoreg,
  output logic             mem_regwrite,
  output logic [RA_W-1:0]  mem_rd,
  output logic             wb_memtoreg,
  output logic             wb_regwrite,
  output logic [RA_W-1:0]  wb_rd,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             br_taken,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             r_ex_branch, r_ex_memread, r_ex_memtoreg, r_ex_memwrite;
  logic             r_ex_alusrc, r_ex_regwrite;
  logic [1:0]       r_ex_aluop;
  logic [RA_W-1:0]  r_ex_rd;
  logic             r_mem_branch, r_mem_memread, r_mem_memwrite, r_mem_memtoreg;
  logic             r_mem_regwrite;
  logic [RA_W-1:0]  r_mem_rd;
  logic             r_wb_memtoreg, r_wb_regwrite;
  logic [RA_W-1:0]  r_wb_rd;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_hz, w_br_taken, w_stall;
  logic             w_nx_branch, w_nx_memread, w_nx_memtoreg, w_nx_memwrite;
  logic             w_nx_alusrc, w_nx_regwrite;
  logic [1:0]       w_nx_aluop;
  logic [RA_W-1:0]  w_nx_rd;

  // x0 as a load destination never creates a dependency
  assign w_hz = r_ex_memread & (r_ex_rd != {RA_W{1'b0}}) & id_valid &
                ((r_ex_rd == id_rs1) | (r_ex_rd == id_rs2));
  assign w_br_taken = r_mem_branch & mem_zero;
  assign w_stall    = w_hz & ~w_br_taken;

  // Next ID/EX contents: scrubbed decode, or a bubble on invalid/stall/squash
  always_comb begin
    w_nx_branch   = 1'b0;
    w_nx_memread  = 1'b0;
    w_nx_memtoreg = 1'b0;
    w_nx_memwrite = 1'b0;
    w_nx_alusrc   = 1'b0;
    w_nx_regwrite = 1'b0;
    w_nx_aluop    = 2'b00;
    w_nx_rd       = {RA_W{1'b0}};
    if (id_valid && !w_hz && !w_br_taken) begin
      w_nx_branch   = id_branch;
      w_nx_memread  = id_memread;
      w_nx_memtoreg = id_memtoreg & id_regwrite;
      w_nx_memwrite = id_memwrite;
      w_nx_alusrc   = id_alusrc;
      w_nx_regwrite = id_regwrite;
      w_nx_aluop    = id_aluop;
      w_nx_rd       = id_regwrite ? id_rd : {RA_W{1'b0}};
    end else begin
      w_nx_rd       = {RA_W{1'b0}};
    end
  end

  // Fetch enables; reset forces a NOP into IF/ID
  always_comb begin
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b1;
    if (reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
    end else if (w_br_taken) begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b1;
    end else if (w_hz) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b0;
    end else begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
    end
  end

  // Stage registers and stall counter; MEM/WB advances even on a squash
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_branch    <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_ex_memtoreg  <= 1'b0;
      r_ex_memwrite  <= 1'b0;
      r_ex_alusrc    <= 1'b0;
      r_ex_regwrite  <= 1'b0;
      r_ex_aluop     <= 2'b00;
      r_ex_rd        <= {RA_W{1'b0}};
      r_mem_branch   <= 1'b0;
      r_mem_memread  <= 1'b0;
      r_mem_memwrite <= 1'b0;
      r_mem_memtoreg <= 1'b0;
      r_mem_regwrite <= 1'b0;
      r_mem_rd       <= {RA_W{1'b0}};
      r_wb_memtoreg  <= 1'b0;
      r_wb_regwrite  <= 1'b0;
      r_wb_rd        <= {RA_W{1'b0}};
      r_stall_cnt    <= {CNT_W{1'b0}};
    end else begin
      r_ex_branch    <= w_nx_branch;
      r_ex_memread   <= w_nx_memread;
      r_ex_memtoreg  <= w_nx_memtoreg;
      r_ex_memwrite  <= w_nx_memwrite;
      r_ex_alusrc    <= w_nx_alusrc;
      r_ex_regwrite  <= w_nx_regwrite;
      r_ex_aluop     <= w_nx_aluop;
      r_ex_rd        <= w_nx_rd;
      r_wb_memtoreg  <= r_mem_memtoreg;
      r_wb_regwrite  <= r_mem_regwrite;
      r_wb_rd        <= r_mem_rd;
      if (w_br_taken) begin
        r_mem_branch   <= 1'b0;
        r_mem_memread  <= 1'b0;
        r_mem_memwrite <= 1'b0;
        r_mem_memtoreg <= 1'b0;
        r_mem_regwrite <= 1'b0;
        r_mem_rd       <= {RA_W{1'b0}};
      end else begin
        r_mem_branch   <= r_ex_branch;
        r_mem_memread  <= r_ex_memread;
        r_mem_memwrite <= r_ex_memwrite;
        r_mem_memtoreg <= r_ex_memtoreg;
        r_mem_regwrite <= r_ex_regwrite;
        r_mem_rd       <= r_ex_rd;
      end
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
    end
  end

  assign ex_branch    = r_ex_branch;
  assign ex_memread   = r_ex_memread;
  assign ex_memtoreg  = r_ex_memtoreg;
  assign ex_memwrite  = r_ex_memwrite;
  assign ex_alusrc    = r_ex_alusrc;
  assign ex_regwrite  = r_ex_regwrite;
  assign ex_aluop     = r_ex_aluop;
  assign ex_rd        = r_ex_rd;
  assign mem_branch   = r_mem_branch;
  assign mem_memread  = r_mem_memread;
  assign mem_memwrite = r_mem_memwrite;
  assign mem_memtoreg = r_mem_memtoreg;
  assign mem_regwrite = r_mem_regwrite;
  assign mem_rd       = r_mem_rd;
  assign wb_memtoreg  = r_wb_memtoreg;
  assign wb_regwrite  = r_wb_regwrite;
  assign wb_rd        = r_wb_rd;
  assign br_taken     = w_br_taken;
  assign stall_cnt    = r_stall_cnt;

endmodule
